// File: rtl/mem_port_arb.sv
// Two-port (instruction / data) arbiter onto a single memory bus.
// One outstanding bus transaction, round-robin grant, per-transaction timeout.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no transaction on the bus; grant a pending/arriving request
// BUSY  | one transaction issued; wait for i_MRdy / i_MErr / timeout
module mem_port_arb #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] i_IAddr,
    input  logic        i_IRdC,
    output logic [31:0] o_IData,
    output logic        o_IRdy,
    output logic        o_IErr,
    input  logic [31:0] i_DAddr,
    input  logic        i_DCmd,
    input  logic        i_DRnW,
    input  logic [3:0]  i_DBen,
    input  logic [31:0] i_DData,
    output logic [31:0] o_DData,
    output logic        o_DRdy,
    output logic        o_DErr,
    output logic [31:0] o_MAddr,
    output logic        o_MCmd,
    output logic        o_MRnW,
    output logic [3:0]  o_MBen,
    output logic [31:0] o_MData,
    input  logic [31:0] i_MData,
    input  logic        i_MRdy,
    input  logic        i_MErr
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state;
    logic        last_d;
    logic [7:0]  cnt;

    logic        i_pend;
    logic [31:0] i_addr_q;
    logic        d_pend;
    logic [31:0] d_addr_q;
    logic        d_rnw_q;
    logic [3:0]  d_ben_q;
    logic [31:0] d_data_q;

    logic busy, timeout_hit, err, rdy, done;
    logic i_fly, d_fly, i_take, d_take, i_req, d_req, grant_i, grant_d;

    // last_d doubles as the in-flight port selector while BUSY
    always_comb begin
        busy        = (state == BUSY);
        timeout_hit = busy && (cnt == 8'(TIMEOUT));
        err         = busy & (i_MErr | timeout_hit);
        rdy         = busy & i_MRdy & ~err;
        done        = err | rdy;
        i_fly       = busy & ~last_d;
        d_fly       = busy & last_d;
        i_take      = i_IRdC & (~(i_pend | i_fly) | (i_fly & done));
        d_take      = i_DCmd & (~(d_pend | d_fly) | (d_fly & done));
        i_req       = ~busy & (i_pend | i_take);
        d_req       = ~busy & (d_pend | d_take);
        grant_d     = d_req & (~i_req | ~last_d);
        grant_i     = i_req & ~grant_d;
    end

    assign o_IRdy  = i_fly & rdy;
    assign o_IErr  = i_fly & err;
    assign o_IData = (i_fly & done) ? i_MData : 32'h0;
    assign o_DRdy  = d_fly & rdy;
    assign o_DErr  = d_fly & err;
    assign o_DData = (d_fly & done) ? i_MData : 32'h0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            last_d   <= 1'b0;
            cnt      <= 8'h0;
            i_pend   <= 1'b0;
            i_addr_q <= 32'h0;
            d_pend   <= 1'b0;
            d_addr_q <= 32'h0;
            d_rnw_q  <= 1'b0;
            d_ben_q  <= 4'h0;
            d_data_q <= 32'h0;
            o_MCmd   <= 1'b0;
            o_MAddr  <= 32'h0;
            o_MRnW   <= 1'b0;
            o_MBen   <= 4'h0;
            o_MData  <= 32'h0;
        end else begin
            if (i_take)
                i_addr_q <= i_IAddr;
            if (d_take) begin
                d_addr_q <= i_DAddr;
                d_rnw_q  <= i_DRnW;
                d_ben_q  <= i_DBen;
                d_data_q <= i_DData;
            end
            i_pend <= (i_pend | i_take) & ~grant_i;
            d_pend <= (d_pend | d_take) & ~grant_d;
            o_MCmd <= 1'b0;

            case (state)
                IDLE: begin
                    // a request arriving this cycle bypasses its slot
                    if (grant_d) begin
                        o_MAddr <= d_pend ? d_addr_q : i_DAddr;
                        o_MRnW  <= d_pend ? d_rnw_q  : i_DRnW;
                        o_MBen  <= d_pend ? d_ben_q  : i_DBen;
                        o_MData <= d_pend ? d_data_q : i_DData;
                    end else if (grant_i) begin
                        o_MAddr <= i_pend ? i_addr_q : i_IAddr;
                        o_MRnW  <= 1'b1;
                        o_MBen  <= 4'hF;
                        o_MData <= 32'h0;
                    end
                    if (grant_i | grant_d) begin
                        o_MCmd <= 1'b1;
                        last_d <= grant_d;
                        cnt    <= 8'h0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (done)
                        state <= IDLE;
                    else
                        cnt <= cnt + 8'h1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: single reads, arbitration, timeout,
// error priority, reset mid-transaction and duplicate-request rejection.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] i_IAddr = '0;
    logic        i_IRdC = 1'b0;
    logic [31:0] o_IData;
    logic        o_IRdy, o_IErr;
    logic [31:0] i_DAddr = '0;
    logic        i_DCmd = 1'b0;
    logic        i_DRnW = 1'b0;
    logic [3:0]  i_DBen = '0;
    logic [31:0] i_DData = '0;
    logic [31:0] o_DData;
    logic        o_DRdy, o_DErr;
    logic [31:0] o_MAddr;
    logic        o_MCmd, o_MRnW;
    logic [3:0]  o_MBen;
    logic [31:0] o_MData;
    logic [31:0] i_MData = '0;
    logic        i_MRdy = 1'b0;
    logic        i_MErr = 1'b0;

    int total = 0;
    int bad   = 0;

    mem_port_arb #(.TIMEOUT(4)) dut (
        .clk(clk), .nrst(nrst),
        .i_IAddr(i_IAddr), .i_IRdC(i_IRdC), .o_IData(o_IData), .o_IRdy(o_IRdy), .o_IErr(o_IErr),
        .i_DAddr(i_DAddr), .i_DCmd(i_DCmd), .i_DRnW(i_DRnW), .i_DBen(i_DBen), .i_DData(i_DData),
        .o_DData(o_DData), .o_DRdy(o_DRdy), .o_DErr(o_DErr),
        .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MRnW(o_MRnW), .o_MBen(o_MBen), .o_MData(o_MData),
        .i_MData(i_MData), .i_MRdy(i_MRdy), .i_MErr(i_MErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
    endtask

    task automatic d_req(input logic [31:0] a, input logic rnw, input logic [3:0] ben, input logic [31:0] d);
        i_DAddr = a; i_DRnW = rnw; i_DBen = ben; i_DData = d; i_DCmd = 1'b1;
    endtask

    task automatic respond(input logic rdy, input logic err, input logic [31:0] d);
        i_MRdy = rdy; i_MErr = err; i_MData = d;
        #1;
    endtask

    task automatic quiet();
        i_IRdC = 1'b0; i_DCmd = 1'b0; i_MRdy = 1'b0; i_MErr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_mcmd", {31'h0, o_MCmd}, 32'h0);
        chk("rst_maddr", o_MAddr, 32'h0);
        chk("rst_resp", {28'h0, o_IRdy, o_IErr, o_DRdy, o_DErr}, 32'h0);
        repeat (2) @(posedge clk);
        #2 nrst = 1'b1;
        tick();

        // single I read, memory answers 3 cycles after o_MCmd
        i_IAddr = 32'h100; i_IRdC = 1'b1;
        tick(); quiet();
        chk("i_mcmd", {31'h0, o_MCmd}, 32'h1);
        chk("i_maddr", o_MAddr, 32'h100);
        chk("i_mrnw", {31'h0, o_MRnW}, 32'h1);
        chk("i_mben", {28'h0, o_MBen}, 32'hF);
        tick();
        chk("i_mcmd_pulse", {31'h0, o_MCmd}, 32'h0);
        chk("i_no_early_rdy", {31'h0, o_IRdy}, 32'h0);
        tick(); tick();
        respond(1'b1, 1'b0, 32'hDEADBEEF);
        chk("i_irdy", {31'h0, o_IRdy}, 32'h1);
        chk("i_idata", o_IData, 32'hDEADBEEF);
        chk("i_drdy_quiet", {31'h0, o_DRdy}, 32'h0);
        tick(); quiet();

        // simultaneous requests after reset: D first, then I, then D again
        reset_pulse();
        tick();
        i_IAddr = 32'h10; i_IRdC = 1'b1;
        d_req(32'h20, 1'b0, 4'h3, 32'h55);
        tick(); quiet();
        chk("rr1_mcmd", {31'h0, o_MCmd}, 32'h1);
        chk("rr1_maddr", o_MAddr, 32'h20);
        chk("rr1_mrnw", {31'h0, o_MRnW}, 32'h0);
        chk("rr1_mben", {28'h0, o_MBen}, 32'h3);
        chk("rr1_mdata", o_MData, 32'h55);
        tick();
        respond(1'b1, 1'b0, 32'h0);
        chk("rr1_drdy", {31'h0, o_DRdy}, 32'h1);
        chk("rr1_irdy", {31'h0, o_IRdy}, 32'h0);
        tick(); quiet();
        chk("rr_gap", {31'h0, o_MCmd}, 32'h0);
        chk("rr_hold", o_MAddr, 32'h20);
        tick();
        chk("rr2_mcmd", {31'h0, o_MCmd}, 32'h1);
        chk("rr2_maddr", o_MAddr, 32'h10);
        chk("rr2_mrnw", {31'h0, o_MRnW}, 32'h1);
        chk("rr2_mben", {28'h0, o_MBen}, 32'hF);
        respond(1'b1, 1'b0, 32'h1234);
        chk("rr2_irdy", {31'h0, o_IRdy}, 32'h1);
        tick(); quiet();
        i_IAddr = 32'h30; i_IRdC = 1'b1;
        d_req(32'h40, 1'b1, 4'hF, 32'h0);
        tick(); quiet();
        chk("rr3_maddr_d", o_MAddr, 32'h40);
        respond(1'b1, 1'b0, 32'h0);
        chk("rr3_drdy", {31'h0, o_DRdy}, 32'h1);
        tick(); quiet();
        tick();
        chk("rr4_mcmd", {31'h0, o_MCmd}, 32'h1);
        chk("rr4_maddr_i", o_MAddr, 32'h30);
        respond(1'b1, 1'b0, 32'h0);
        tick(); quiet();

        // error wins over ready
        i_IAddr = 32'h500; i_IRdC = 1'b1;
        tick(); quiet();
        respond(1'b1, 1'b1, 32'hAAAA5555);
        chk("both_ierr", {31'h0, o_IErr}, 32'h1);
        chk("both_irdy", {31'h0, o_IRdy}, 32'h0);
        tick(); quiet();

        // duplicate D pulse while in flight is dropped
        d_req(32'h200, 1'b1, 4'hF, 32'h0);
        tick(); quiet();
        chk("dup_mcmd", {31'h0, o_MCmd}, 32'h1);
        d_req(32'h300, 1'b0, 4'h1, 32'h9);
        tick(); quiet();
        chk("dup_hold", o_MAddr, 32'h200);
        respond(1'b1, 1'b0, 32'h77);
        chk("dup_drdy", {31'h0, o_DRdy}, 32'h1);
        chk("dup_ddata", o_DData, 32'h77);
        tick(); quiet();
        tick();
        chk("dup_no_reissue", {31'h0, o_MCmd}, 32'h0);
        tick();
        chk("dup_no_reissue2", {31'h0, o_MCmd}, 32'h0);
        chk("dup_addr_kept", o_MAddr, 32'h200);

        // timeout: D read never answered, TIMEOUT=4
        d_req(32'h400, 1'b1, 4'hF, 32'h0);
        tick(); quiet();
        chk("to_mcmd", {31'h0, o_MCmd}, 32'h1);
        tick(); tick(); tick();
        chk("to_not_yet", {31'h0, o_DErr}, 32'h0);
        tick();
        chk("to_derr", {31'h0, o_DErr}, 32'h1);
        chk("to_drdy", {31'h0, o_DRdy}, 32'h0);
        tick();
        respond(1'b1, 1'b0, 32'h1);
        chk("late_rdy", {30'h0, o_IRdy, o_DRdy}, 32'h0);
        chk("late_err", {30'h0, o_IErr, o_DErr}, 32'h0);
        tick(); quiet();

        // reset while BUSY with an I request pending
        d_req(32'h600, 1'b1, 4'hF, 32'h0);
        tick(); quiet();
        i_IAddr = 32'h700; i_IRdC = 1'b1;
        tick(); quiet();
        respond(1'b1, 1'b0, 32'hCAFE);
        chk("pre_rst_drdy", {31'h0, o_DRdy}, 32'h1);
        nrst = 1'b0;
        #1;
        chk("arst_drdy", {31'h0, o_DRdy}, 32'h0);
        chk("arst_ddata", o_DData, 32'h0);
        chk("arst_maddr", o_MAddr, 32'h0);
        @(posedge clk);
        #2 nrst = 1'b1;
        quiet();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_idle", {31'h0, o_MCmd}, 32'h0);
        end
        i_IAddr = 32'h800; i_IRdC = 1'b1;
        d_req(32'h900, 1'b1, 4'hF, 32'h0);
        tick(); quiet();
        chk("post_rst_mcmd", {31'h0, o_MCmd}, 32'h1);
        chk("post_rst_d_wins", o_MAddr, 32'h900);
        respond(1'b1, 1'b0, 32'h0);
        tick(); quiet();
        tick();
        chk("post_rst_i_next", o_MAddr, 32'h800);
        respond(1'b1, 1'b0, 32'h0);
        tick(); quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
